// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared types and helpers for the spiking-network step scheduler:
//             FSM state encoding, default state width and saturating add.
//  Revision : 1.0  initial release
// ============================================================================
package snn_pkg;

    // Step scheduler FSM states, two-bit encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_REQ    = 2'd2,
        ST_COMMIT = 2'd3
    } fsm_e;

    // Default width of membrane state and input current
    localparam int STATE_W_DEF = 8;

    // Unsigned add of two operands, clamped to 2^w-1 (w up to 32)
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : snn_tick_gen
//  Purpose  : Time-step prescaler. Counts 0..TICK_PERIOD-1 while enabled and
//             flags the last count as the step tick; held at 0 when disabled.
//  Revision : 1.0  initial release
// ============================================================================
module snn_tick_gen #(
    parameter int TICK_PERIOD = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int              CNT_W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running step counter, parked at zero whenever the enable is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Gate with the enable so a drop on the last count suppresses the tick
    assign tick_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/snn_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : snn_step_scheduler
//  Purpose  : Time-multiplexes one shared leaky neuron core over NUM_NEURONS
//             neurons. Each step samples input spikes, walks every neuron
//             through the core over a valid/ack handshake, writes back the
//             new membrane states and publishes the step's spike vector.
//  Revision : 1.0  initial release
// ============================================================================
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int                 NUM_NEURONS = 8,
    parameter int                 STATE_W     = STATE_W_DEF,
    parameter logic [STATE_W-1:0] W_IN        = STATE_W'(40),
    parameter logic [STATE_W-1:0] W_REC       = STATE_W'(24),
    parameter int                 TICK_PERIOD = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_i,
    input  logic [NUM_NEURONS-1:0]         in_spike_i,
    output logic                           core_req_o,
    output logic [$clog2(NUM_NEURONS)-1:0] core_idx_o,
    output logic [STATE_W-1:0]             core_state_o,
    output logic [STATE_W-1:0]             core_current_o,
    input  logic                           core_ack_i,
    input  logic [STATE_W-1:0]             core_state_nxt_i,
    input  logic                           core_spike_i,
    output logic [NUM_NEURONS-1:0]         spike_out_o,
    output logic                           step_done_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    localparam int               IDX_W    = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    fsm_e                   fsm_q, fsm_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   w_tick;
    logic                   w_wr;
    logic [NUM_NEURONS-1:0] in_q;
    logic [NUM_NEURONS-1:0] prev_q;
    logic [NUM_NEURONS-1:0] acc_q;
    logic [STATE_W-1:0]     mem_q [NUM_NEURONS];
    logic [NUM_NEURONS-1:0] spike_out_q;
    logic                   step_done_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic [IDX_W-1:0]       w_prev_idx;
    logic [STATE_W-1:0]     w_in_term;
    logic [STATE_W-1:0]     w_rec_term;

    snn_tick_gen #(
        .TICK_PERIOD (TICK_PERIOD)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en_i),
        .tick_o (w_tick)
    );

    // FSM and neuron index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
        end
    end

    // Next-state decode; an ack outside REQ is simply not looked at
    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        w_wr  = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (w_tick) fsm_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                idx_d = '0;
                fsm_d = ST_REQ;
            end
            ST_REQ: begin
                if (core_ack_i) begin
                    w_wr = 1'b1;
                    if (idx_q == IDX_LAST) fsm_d = ST_COMMIT;
                    else                   idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_COMMIT: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Per-neuron storage: sampled inputs, membrane states, step spike accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= '0;
            acc_q  <= '0;
            prev_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
        end else begin
            if (fsm_q == ST_SAMPLE) in_q <= in_spike_i;
            if (w_wr) begin
                mem_q[idx_q] <= core_state_nxt_i;
                acc_q[idx_q] <= core_spike_i;
            end
            if (fsm_q == ST_COMMIT) prev_q <= acc_q;
        end
    end

    // Registered status outputs; overrun is sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_out_q <= '0;
            step_done_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (fsm_q == ST_COMMIT) spike_out_q <= acc_q;
            step_done_q <= (fsm_q == ST_COMMIT);
            busy_q      <= (fsm_d != ST_IDLE);
            if (w_tick && (fsm_q != ST_IDLE)) overrun_q <= 1'b1;
        end
    end

    // Recurrent source wraps: neuron 0 listens to the last neuron
    assign w_prev_idx = (idx_q == '0) ? IDX_LAST : (idx_q - IDX_W'(1));
    assign w_in_term  = in_q[idx_q]        ? W_IN  : '0;
    assign w_rec_term = prev_q[w_prev_idx] ? W_REC : '0;

    // Core-facing signals come only from registered FSM, index and arrays
    assign core_req_o     = (fsm_q == ST_REQ);
    assign core_idx_o     = idx_q;
    assign core_state_o   = mem_q[idx_q];
    assign core_current_o = STATE_W'(sat_add(32'(w_in_term), 32'(w_rec_term), STATE_W));

    assign spike_out_o = spike_out_q;
    assign step_done_o = step_done_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire
